fifo_wr_ctrl: RTL
=================

// Module: fifo_wr_ctrl
// PURPOSE
//  Write-side controller for the dual-clock FIFO, directly upstream of fifomem.
//  Generates waddr, wclken and wfull for the memory, and a Gray write pointer for the read domain.
//  Syncs the read domain's Gray pointer into wclk through 2 flops and reports fill level.
//  Latches a sticky overflow error. All logic runs on wclk only.
// PARAMETERS
//  ADDRSIZE     4   memory address bits; DEPTH = 1<<ADDRSIZE; pointers are ADDRSIZE+1 bits
//  AFULL_THRESH 12  wafull asserts when level >= this; legal range 1..DEPTH
// PORTS
//  wclk        in   1           write clock
//  wrst_n      in   1           synchronous active-low reset
//  winc        in   1           push request from the producer
//  wovf_clr    in   1           clears woverflow
//  wptr_rd     in   ADDRSIZE+1  read pointer, Gray code, from the rclk domain (async to wclk)
//  waddr       out  ADDRSIZE    write address to fifomem (= wbin[ADDRSIZE-1:0])
//  wclken      out  1           write enable to fifomem: winc & ~wfull (combinational)
//  wfull       out  1           FIFO full, registered
//  wptr        out  ADDRSIZE+1  write pointer, Gray code, registered, to the read-side synchroniser
//  wlevel      out  ADDRSIZE+1  occupancy seen from the write side, 0..DEPTH
//  wafull      out  1           almost full
//  woverflow   out  1           sticky: a push was attempted while full
// BEHAVIOUR
//  - Reset (wrst_n==0 at a wclk edge) clears wbin, wptr, wq1_rptr, wq2_rptr, wfull, wlevel, wafull and woverflow.
//    waddr therefore reads 0 after reset. Reset overrides every other input.
//  - Sync: wq1_rptr <= wptr_rd; wq2_rptr <= wq1_rptr. No logic between the flops.
//  - Push: push = winc & ~wfull; wbinnext = wbin + push (mod 2^(ADDRSIZE+1)).
//    wgraynext = (wbinnext>>1) ^ wbinnext; wbin <= wbinnext; wptr <= wgraynext.
//  - Full: wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
//    The push that fills the FIFO raises wfull on the same edge that writes the last entry.
//  - Full-side latency: a read-pointer change reaches wfull after 3 wclk edges (2 sync edges + 1 register edge).
//    wfull is pessimistic and never falsely deasserts.
//  - Push while full: wclken=0, pointers hold, fifomem is not written. woverflow <= 1 on the next edge.
//  - Overflow clear: woverflow clears on wovf_clr. If set and clear occur in the same cycle, set wins.
//  - Wrap: wbin rolls over at 2^(ADDRSIZE+1). The extra MSB separates full from empty.
//    waddr wraps DEPTH-1 -> 0 without a gap.
//  - Empty is not this block's concern. The read-side block owns rempty.
//  - Reset mid-operation clears pointers only. The read domain must be reset in the same window;
//    the enclosing FIFO guarantees this. No flush handshake.
// CONFIGURATION
//  `FIFO_WR_LEVEL_EN defined:
//    rbin = gray2bin(wq2_rptr).
//    wlevel <= wbinnext - rbin (mod 2^(ADDRSIZE+1)).
//    wafull <= (that value >= AFULL_THRESH).
//    wlevel==DEPTH exactly when wfull==1.
//  `FIFO_WR_LEVEL_EN undefined:
//    wlevel and wafull are tied to 0. No gray2bin logic or level registers are built.
//    Full and overflow behaviour are unchanged.
// TESTING  (ADDRSIZE=4, AFULL_THRESH=12, wptr_rd held 0 unless stated)
//  1. Reset: wrst_n=0 for 2 edges with winc=1
//     -> all outputs 0 and no wclken pulse while in reset.
//  2. 16 consecutive pushes
//     -> waddr steps 0..15 then 0; wfull=1 after the 16th edge; wptr=5'b11000.
//     -> with _EN, wlevel=16; wafull rises after the 12th edge.
//  3. 17th push while full
//     -> wclken=0; wptr holds; woverflow=1 next edge.
//     -> wovf_clr pulse clears it; wovf_clr held together with another push while full leaves it 1.
//  4. While full, drive wptr_rd=5'b00001 (Gray of 1)
//     -> wfull drops exactly 3 edges later; with _EN, wlevel=15 on that edge.
//  5. Wrap: drive 40 pushes interleaved with read-pointer advances that keep level <= 8
//     -> wbin wraps through 31->0; wfull never asserts; no overflow.
//  6. Rebuild without `FIFO_WR_LEVEL_EN and rerun tests 2-4
//     -> wlevel and wafull stay 0; every other response is identical.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
// Write-side controller of the dual-clock FIFO. Owns the binary/Gray write
// pointer, the two-flop synchroniser for the read pointer, the registered full
// flag and the sticky overflow flag. Everything runs on wclk.
//
// Build option: define FIFO_WR_LEVEL_EN to build the occupancy outputs
// (wlevel, wafull). Without it both outputs are tied low and no Gray-to-binary
// conversion or level registers exist.
module fifo_wr_ctrl #(
   parameter int ADDRSIZE     = 4,
   parameter int AFULL_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                winc,
   input  logic                wovf_clr,
   input  logic [ADDRSIZE:0]   wptr_rd,
   output logic [ADDRSIZE-1:0] waddr,
   output logic                wclken,
   output logic                wfull,
   output logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wafull,
   output logic                woverflow
);

   logic [ADDRSIZE:0] wbin_q,     wbin_d;
   logic [ADDRSIZE:0] wptr_q,     wptr_d;
   logic [ADDRSIZE:0] wq1_rptr_q, wq1_rptr_d;
   logic [ADDRSIZE:0] wq2_rptr_q, wq2_rptr_d;
   logic              wfull_q,    wfull_d;
   logic              wovf_q,     wovf_d;

   logic              push;
   logic [ADDRSIZE:0] full_match;

   // Push qualifier. Reset is folded in so fifomem sees no write strobe while
   // wrst_n is low, even though wfull is already cleared at that point.
   always_comb begin
      push = winc & ~wfull_q & wrst_n;
   end

   // Next binary / Gray write pointer.
   always_comb begin
      wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, push};
      wptr_d = (wbin_d >> 1) ^ wbin_d;
   end

   // Full when the next Gray pointer equals the synchronised read pointer with
   // its two MSBs inverted, i.e. the write side is exactly one lap ahead.
   // The stale read pointer can only make this pessimistic, never optimistic.
   always_comb begin
      full_match = {~wq2_rptr_q[ADDRSIZE:ADDRSIZE-1], wq2_rptr_q[ADDRSIZE-2:0]};
      wfull_d    = (wptr_d == full_match);
   end

   // Sticky overflow: a refused push sets it, wovf_clr clears it, set wins.
   always_comb begin
      wovf_d = wovf_q;
      if (winc && wfull_q) begin
         wovf_d = 1'b1;
      end else if (wovf_clr) begin
         wovf_d = 1'b0;
      end
   end

   // Two-stage synchroniser inputs; nothing combinational between the stages.
   always_comb begin
      wq1_rptr_d = wptr_rd;
      wq2_rptr_d = wq1_rptr_q;
   end

   // Read-pointer synchroniser flops.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wq1_rptr_q <= '0;
         wq2_rptr_q <= '0;
      end else begin
         wq1_rptr_q <= wq1_rptr_d;
         wq2_rptr_q <= wq2_rptr_d;
      end
   end

   // Write pointer, full and overflow state.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
         wovf_q  <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wptr_d;
         wfull_q <= wfull_d;
         wovf_q  <= wovf_d;
      end
   end

`ifdef FIFO_WR_LEVEL_EN
   localparam int PW = ADDRSIZE + 1;
   localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [ADDRSIZE:0] rbin;
   logic [ADDRSIZE:0] wlevel_q, wlevel_d;
   logic              wafull_q, wafull_d;

   function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
      logic [ADDRSIZE:0] b;
      b[ADDRSIZE] = g[ADDRSIZE];
      for (int i = ADDRSIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Occupancy after this edge's push, against the synchronised read pointer.
   // Uses the same read pointer as the full compare, so level==DEPTH tracks wfull.
   always_comb begin
      rbin     = gray2bin(wq2_rptr_q);
      wlevel_d = wbin_d - rbin;
      wafull_d = (wlevel_d >= AFULL_LVL);
   end

   // Level and almost-full registers.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wlevel_q <= '0;
         wafull_q <= 1'b0;
      end else begin
         wlevel_q <= wlevel_d;
         wafull_q <= wafull_d;
      end
   end

   assign wlevel = wlevel_q;
   assign wafull = wafull_q;
`else
   assign wlevel = '0;
   assign wafull = 1'b0;
`endif

   assign waddr     = wbin_q[ADDRSIZE-1:0];
   assign wclken    = push;
   assign wfull     = wfull_q;
   assign wptr      = wptr_q;
   assign woverflow = wovf_q;

endmodule
